// File: rtl/z80_bus_slave_if.sv
// Z80 pin-side and backend-side signal bundle for z80_bus_slave.
//  CPU pins : nM1 nMREQ nIORQ nRD nWR nRFSH (active-low), A[15:0], d_in[7:0]
//  D drive  : d_out[7:0], d_oe, nWAIT (active-low wait request)
//  Backend  : req, req_we, req_io, req_m1, req_addr[15:0], req_wdata[7:0],
//             ack, rdata[7:0], err (timeout pulse)
// slave modport is the bus slave; master modport is the CPU + backing store.
interface z80_bus_slave_if;
  logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
  logic [15:0] A;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        nWAIT;
  logic        req, req_we, req_io, req_m1;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic        err;

  modport slave (
    input  nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, A, d_in, ack, rdata,
    output d_out, d_oe, nWAIT, req, req_we, req_io, req_m1, req_addr, req_wdata, err
  );

  modport master (
    output nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, A, d_in, ack, rdata,
    input  d_out, d_oe, nWAIT, req, req_we, req_io, req_m1, req_addr, req_wdata, err
  );
endinterface

// File: rtl/z80_bus_slave.sv
// Z80 bus slave: decodes each CPU bus cycle into one req/ack transaction to a
// backing store, inserts wait states on nWAIT, drives D on reads and forces
// completion (err pulse, VECTOR data) when the backend stalls.
// Ports:
//  CLK     CPU clock, all state on the rising edge
//  nRESET  asynchronous active-low reset
//  bus     z80_bus_slave_if.slave (CPU pins, D drive, backend handshake)
module z80_bus_slave #(
  parameter int unsigned MIN_WAIT = 1,
  parameter int unsigned TIMEOUT  = 64,
  parameter bit          INTA_IO  = 1'b1,
  parameter logic [7:0]  VECTOR   = 8'hFF
) (
  input logic            CLK,
  input logic            nRESET,
  z80_bus_slave_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
  typedef enum logic [1:0] {K_MEM, K_IO, K_INTA} kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d, kind_sel;
  logic        req_q, req_d;
  logic        req_we_q, req_we_d;
  logic        req_io_q, req_io_d;
  logic        req_m1_q, req_m1_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [7:0]  req_wdata_q, req_wdata_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  logic        nwait_q, nwait_d;
  logic        err_q, err_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        acked_q, acked_d;
  logic        armed_q, armed_d;

  logic mem, io, inta, any_strobe, cyc_active, got_ack;

  always_comb begin
    mem        = ~bus.nMREQ & bus.nRFSH & (~bus.nRD | ~bus.nWR);
    io         = ~bus.nIORQ & bus.nM1   & (~bus.nRD | ~bus.nWR);
    inta       = ~bus.nIORQ & ~bus.nM1;
    any_strobe = mem | io | inta;
    kind_sel   = inta ? K_INTA : (io ? K_IO : K_MEM);
    // The captured cycle stays active while its own space strobe and data strobe are low.
    case (kind_q)
      K_MEM:   cyc_active = ~bus.nMREQ & (req_we_q ? ~bus.nWR : ~bus.nRD);
      K_IO:    cyc_active = ~bus.nIORQ & (req_we_q ? ~bus.nWR : ~bus.nRD);
      default: cyc_active = ~bus.nIORQ;
    endcase
    got_ack = acked_q | (bus.ack & req_q);
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    req_d       = req_q;
    req_we_d    = req_we_q;
    req_io_d    = req_io_q;
    req_m1_d    = req_m1_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    d_out_d     = d_out_q;
    d_oe_d      = d_oe_q;
    nwait_d     = nwait_q;
    err_d       = 1'b0;
    wcnt_d      = wcnt_q;
    tmo_d       = tmo_q;
    acked_d     = acked_q;
    armed_d     = armed_q;
    case (state_q)
      S_IDLE: begin
        armed_d = ~any_strobe;
        if (any_strobe && armed_q) begin
          kind_d      = kind_sel;
          req_addr_d  = bus.A;
          req_wdata_d = bus.d_in;
          req_we_d    = ~bus.nWR;
          req_io_d    = io | inta;
          req_m1_d    = ~bus.nM1;
          nwait_d     = 1'b0;
          d_oe_d      = 1'b0;
          wcnt_d      = 4'(MIN_WAIT);
          tmo_d       = '0;
          armed_d     = 1'b0;
          state_d     = S_REQ;
          // Local intack answer rides through REQ as an already-acked access
          // without raising req, so the wait-state count still applies.
          if (inta && !INTA_IO) begin
            req_d   = 1'b0;
            acked_d = 1'b1;
            d_out_d = VECTOR;
          end else begin
            req_d   = 1'b1;
            acked_d = 1'b0;
          end
        end
      end
      S_REQ: begin
        if (wcnt_q != '0) wcnt_d = wcnt_q - 4'd1;
        if (bus.ack && req_q) begin
          req_d   = 1'b0;
          acked_d = 1'b1;
          if (!req_we_q) d_out_d = bus.rdata;
        end
        if (got_ack && wcnt_q == '0) begin
          nwait_d = 1'b1;
          d_oe_d  = ~req_we_q & cyc_active;
          state_d = S_HOLD;
        end else if (!got_ack && tmo_q == TW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          d_out_d = VECTOR;
          nwait_d = 1'b1;
          d_oe_d  = ~req_we_q & cyc_active;
          state_d = S_HOLD;
        end else if (!got_ack) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_HOLD: begin
        nwait_d = 1'b1;
        if (!cyc_active) begin
          d_oe_d  = 1'b0;
          armed_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          d_oe_d = ~req_we_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= S_IDLE;
      kind_q      <= K_MEM;
      req_q       <= 1'b0;
      req_we_q    <= 1'b0;
      req_io_q    <= 1'b0;
      req_m1_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
      nwait_q     <= 1'b1;
      err_q       <= 1'b0;
      wcnt_q      <= '0;
      tmo_q       <= '0;
      acked_q     <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      req_q       <= req_d;
      req_we_q    <= req_we_d;
      req_io_q    <= req_io_d;
      req_m1_q    <= req_m1_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      nwait_q     <= nwait_d;
      err_q       <= err_d;
      wcnt_q      <= wcnt_d;
      tmo_q       <= tmo_d;
      acked_q     <= acked_d;
      armed_q     <= armed_d;
    end
  end

  assign bus.req       = req_q;
  assign bus.req_we    = req_we_q;
  assign bus.req_io    = req_io_q;
  assign bus.req_m1    = req_m1_q;
  assign bus.req_addr  = req_addr_q;
  assign bus.req_wdata = req_wdata_q;
  assign bus.d_out     = d_out_q;
  assign bus.d_oe      = d_oe_q;
  assign bus.nWAIT     = nwait_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_z80_bus_slave.sv
// Testbench for z80_bus_slave: table of directed bus cycles, hand sequences for
// refresh, reset abort and forwarded intack, then random cycles checked against
// a closed-form model of wait length, data and timeout.
module tb_z80_bus_slave;
  localparam int unsigned MW  = 1;
  localparam int unsigned TO  = 64;
  localparam logic [7:0]  VEC = 8'hFF;

  typedef struct {
    int          kind;      // 0 mem, 1 io, 2 intack, 3 mem+io overlap
    bit          we;
    bit          m1;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          ackd;      // edge index (after req rise) at which ack is sampled
    logic [7:0]  rdata;
    bit          exp_req;
    int          exp_wait;
    logic [7:0]  exp_dout;
    bit          exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_io_n = 1'b0;
  logic p_nM1 = 1'b1, p_nMREQ = 1'b1, p_nIORQ = 1'b1, p_nRD = 1'b1, p_nWR = 1'b1, p_nRFSH = 1'b1;
  logic [15:0] p_A = '0;
  logic [7:0]  p_din = '0;
  logic        ack = 1'b0, ack_io = 1'b0;
  logic [7:0]  rdata = '0, rdata_io = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  z80_bus_slave_if b0 ();
  z80_bus_slave_if b1 ();

  assign b0.nM1 = p_nM1;   assign b1.nM1 = p_nM1;
  assign b0.nMREQ = p_nMREQ; assign b1.nMREQ = p_nMREQ;
  assign b0.nIORQ = p_nIORQ; assign b1.nIORQ = p_nIORQ;
  assign b0.nRD = p_nRD;   assign b1.nRD = p_nRD;
  assign b0.nWR = p_nWR;   assign b1.nWR = p_nWR;
  assign b0.nRFSH = p_nRFSH; assign b1.nRFSH = p_nRFSH;
  assign b0.A = p_A;       assign b1.A = p_A;
  assign b0.d_in = p_din;  assign b1.d_in = p_din;
  assign b0.ack = ack;     assign b1.ack = ack_io;
  assign b0.rdata = rdata; assign b1.rdata = rdata_io;

  z80_bus_slave #(.MIN_WAIT(MW), .TIMEOUT(TO), .INTA_IO(1'b0), .VECTOR(VEC))
    u_dut (.CLK(clk), .nRESET(rst_n), .bus(b0));

  z80_bus_slave #(.MIN_WAIT(0), .TIMEOUT(8), .INTA_IO(1'b1), .VECTOR(VEC))
    u_dut_io (.CLK(clk), .nRESET(rst_io_n), .bus(b1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int kind, input bit we, input bit m1, input logic [15:0] a,
                              input logic [7:0] wd, input int ackd, input logic [7:0] rd,
                              input bit e_req, input int e_wait, input logic [7:0] e_dout,
                              input bit e_err);
    vec_t v;
    v.kind = kind; v.we = we; v.m1 = m1; v.addr = a; v.wdata = wd; v.ackd = ackd; v.rdata = rd;
    v.exp_req = e_req; v.exp_wait = e_wait; v.exp_dout = e_dout; v.exp_err = e_err;
    return v;
  endfunction

  // Reference: an access lasts until both the backend has answered and MIN_WAIT
  // extra cycles have elapsed, unless TIMEOUT REQ cycles pass unanswered.
  function automatic vec_t model(input int kind, input bit we, input bit m1, input logic [15:0] a,
                                 input logic [7:0] wd, input int ackd, input logic [7:0] rd);
    vec_t v;
    bit   w;
    w = (kind == 2) ? 1'b0 : we;
    v = mk(kind, w, (kind == 0) ? (m1 & ~w) : 1'b0, a, wd, ackd, rd, 1'b1, 0, rd, 1'b0);
    if (kind == 2) begin
      v.exp_req = 1'b0; v.exp_wait = int'(MW) + 1; v.exp_dout = VEC;
    end else if (ackd <= int'(TO)) begin
      v.exp_wait = (ackd > int'(MW) + 1) ? ackd : int'(MW) + 1;
    end else begin
      v.exp_wait = int'(TO); v.exp_dout = VEC; v.exp_err = 1'b1;
    end
    return v;
  endfunction

  task automatic idle_pins();
    p_nM1 = 1'b1; p_nMREQ = 1'b1; p_nIORQ = 1'b1; p_nRD = 1'b1; p_nWR = 1'b1; p_nRFSH = 1'b1;
  endtask

  task automatic set_pins(input vec_t v);
    idle_pins();
    case (v.kind)
      0:       begin p_nMREQ = 1'b0; p_nM1 = ~v.m1; p_nRD = v.we; p_nWR = ~v.we; end
      1:       begin p_nIORQ = 1'b0; p_nRD = v.we; p_nWR = ~v.we; end
      2:       begin p_nIORQ = 1'b0; p_nM1 = 1'b0; end
      default: begin p_nMREQ = 1'b0; p_nIORQ = 1'b0; p_nRD = v.we; p_nWR = ~v.we; end
    endcase
  endtask

  task automatic run_txn(input vec_t v);
    int L;
    bit bad_req, bad_fld, bad_oe, exp_r, e_we, e_io, e_m1, e_rd;
    e_we = v.we && (v.kind != 2);
    e_io = (v.kind != 0);
    e_m1 = (v.kind == 2) || (v.kind == 0 && v.m1);
    e_rd = ~e_we;
    idle_pins(); ack = 1'b0;
    @(posedge clk); #1;
    set_pins(v); p_A = v.addr; p_din = v.wdata; rdata = v.rdata;
    @(posedge clk); #1;
    chk("nwait_start", b0.nWAIT, 1'b0);
    chk("req_start", b0.req, v.exp_req);
    if (v.exp_req)
      chk("req_fields", {b0.req_we, b0.req_io, b0.req_m1, b0.req_addr, b0.req_wdata},
          {e_we, e_io, e_m1, v.addr, v.wdata});
    bad_req = 0; bad_fld = 0; bad_oe = 0; L = 0;
    ack = (v.ackd == 1);
    for (int j = 1; j <= 200; j++) begin
      p_A = 16'($urandom); p_din = 8'($urandom);
      @(posedge clk); #1;
      exp_r = v.exp_req && (j < v.ackd) && (j < int'(TO));
      if (b0.req !== exp_r) bad_req = 1;
      if (b0.req && ({b0.req_we, b0.req_io, b0.req_m1, b0.req_addr, b0.req_wdata} !==
                     {e_we, e_io, e_m1, v.addr, v.wdata})) bad_fld = 1;
      if (b0.d_oe && (b0.req || !b0.nWAIT)) bad_oe = 1;
      ack = (j + 1 == v.ackd);
      if (b0.nWAIT) begin L = j; break; end
    end
    ack = 1'b0;
    chk("req_timing", bad_req, 1'b0);
    chk("req_stable", bad_fld, 1'b0);
    chk("doe_in_req", bad_oe, 1'b0);
    chk("wait_len", 64'(L), 64'(v.exp_wait));
    chk("err_flag", b0.err, v.exp_err);
    chk("doe_hold", b0.d_oe, e_rd);
    if (e_rd) chk("dout", b0.d_out, v.exp_dout);
    @(posedge clk); #1;
    chk("held_state", {b0.err, b0.d_oe, b0.nWAIT}, {1'b0, e_rd, 1'b1});
    idle_pins();
    @(posedge clk); #1;
    chk("doe_release", b0.d_oe, 1'b0);
    if (v.exp_err) begin
      ack = 1'b1; rdata = ~v.rdata;
      @(posedge clk); #1;
      ack = 1'b0;
      chk("late_ack", {b0.req, b0.err, b0.d_out, b0.nWAIT}, {1'b0, 1'b0, VEC, 1'b1});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    bit   bad;
    tbl[0] = mk(0, 0, 1, 16'h0100, 8'h00, 1,    8'h3E, 1, 2,  8'h3E, 0); // opcode fetch
    tbl[1] = mk(0, 0, 0, 16'h1234, 8'h00, 3,    8'hA5, 1, 3,  8'hA5, 0); // mem read, ack 2 after req
    tbl[2] = mk(1, 1, 0, 16'h00FE, 8'h3C, 1,    8'h00, 1, 2,  8'h00, 0); // IO write
    tbl[3] = mk(2, 0, 0, 16'h0038, 8'h00, 1000, 8'h00, 0, 2,  8'hFF, 0); // local intack
    tbl[4] = mk(0, 0, 0, 16'hBEEF, 8'h00, 1000, 8'h11, 1, 64, 8'hFF, 1); // timeout
    tbl[5] = mk(3, 0, 0, 16'h0042, 8'h00, 2,    8'h77, 1, 2,  8'h77, 0); // io wins over mem
    tbl[6] = mk(0, 1, 0, 16'h8000, 8'hC3, 5,    8'h00, 1, 5,  8'h00, 0); // slow mem write
    tbl[7] = mk(0, 0, 0, 16'h7777, 8'h00, 64,   8'h99, 1, 64, 8'h99, 0); // ack on last REQ cycle

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state",
        {b0.req, b0.req_we, b0.req_io, b0.req_m1, b0.req_addr, b0.req_wdata,
         b0.d_out, b0.d_oe, b0.nWAIT, b0.err},
        {4'b0000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0});
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i]);
      if (i == 0) begin
        // refresh directly after the fetch must not start an access
        @(posedge clk); #1;
        p_nMREQ = 1'b0; p_nRFSH = 1'b0; p_A = 16'h0055;
        bad = 0;
        repeat (3) begin
          @(posedge clk); #1;
          if (b0.req || !b0.nWAIT) bad = 1;
        end
        chk("refresh_no_req", bad, 1'b0);
        idle_pins();
      end
    end

    // reset asserted mid-access aborts at once; a still-held strobe does not retrigger
    idle_pins();
    @(posedge clk); #1;
    p_nMREQ = 1'b0; p_nRD = 1'b0; p_A = 16'h4321;
    @(posedge clk); #1;
    chk("rst_pre_req", b0.req, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_abort", {b0.req, b0.nWAIT, b0.d_oe}, 3'b010);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (b0.req || !b0.nWAIT) bad = 1;
    end
    chk("no_retrigger", bad, 1'b0);
    run_txn(mk(0, 0, 0, 16'h4321, 8'h00, 2, 8'h5C, 1, 2, 8'h5C, 0));

    // forwarded intack on the INTA_IO=1, MIN_WAIT=0 instance with same-cycle ack
    idle_pins(); p_din = 8'h00;
    @(posedge clk); #1;
    rst_io_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    p_nIORQ = 1'b0; p_nM1 = 1'b0; p_A = 16'h0038;
    @(posedge clk); #1;
    chk("inta_fwd_req", {b1.req, b1.req_we, b1.req_io, b1.req_m1, b1.nWAIT, b1.req_addr, b1.req_wdata},
        {5'b10110, 16'h0038, 8'h00});
    ack_io = 1'b1; rdata_io = 8'h5A;
    @(posedge clk); #1;
    ack_io = 1'b0;
    chk("inta_fwd_done", {b1.req, b1.nWAIT, b1.d_oe, b1.err, b1.d_out}, {4'b0110, 8'h5A});
    idle_pins();
    @(posedge clk); #1;
    chk("inta_fwd_release", b1.d_oe, 1'b0);
    rst_io_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) begin
      int k, r, ad;
      bit w, m;
      k  = int'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      m  = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      ad = (r < 8) ? (r % 6) + 1 : ((r == 8) ? int'(TO) : int'(TO) + 10);
      run_txn(model(k, w, m, 16'($urandom), 8'($urandom), ad, 8'($urandom)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
